// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: field width, opcode encodings and FSM state type shared by the
// alu_seq sequencer and its bench.
package alu_seq_pkg;

  localparam int FIELD_W = 163;
  localparam int CNT_W   = 8;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_SQR = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADD      = 3'd1,
    ST_MUL_GO   = 3'd2,
    ST_MUL_WAIT = 3'd3,
    ST_SQR      = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  // A zero repeat count still performs one squaring.
  function automatic logic [CNT_W-1:0] sqr_count(input logic [CNT_W-1:0] cnt);
    return (cnt == '0) ? CNT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// alu_seq: command sequencer for an external GF(2^163) field ALU (ADD, MUL, SQR).
// Define ALU_SEQ_SQR_REPEAT_EN to make SQR repeat cmd_cnt times; otherwise SQR squares once.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = FIELD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [CNT_W-1:0]  cmd_cnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_err,
  output logic              busy,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_ss,
  output logic              alu_st,
  output logic              alu_sy,
  output logic              alu_m_start,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_m_done
);

  state_t            state;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [1:0]        op_r;
  logic              sqr_last;

`ifdef ALU_SEQ_SQR_REPEAT_EN
  logic [CNT_W-1:0]  cnt_rem;
  assign sqr_last = (cnt_rem == CNT_W'(1));
`else
  logic              unused_cnt;
  assign unused_cnt = ^cmd_cnt;
  assign sqr_last   = 1'b1;
`endif

  assign alu_a   = op_a;
  assign alu_b   = op_b;
  // The error flag rides on the registered opcode so it can only show with a response.
  assign rsp_err = rsp_valid && (op_r == OP_ILL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      busy        <= 1'b0;
      alu_ss      <= 1'b0;
      alu_st      <= 1'b0;
      alu_sy      <= 1'b0;
      alu_m_start <= 1'b0;
      rsp_y       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_r        <= OP_ADD;
`ifdef ALU_SEQ_SQR_REPEAT_EN
      cnt_rem     <= '0;
`endif
    end else begin
      alu_m_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_a      <= cmd_a;
            op_b      <= cmd_b;
            op_r      <= cmd_op;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef ALU_SEQ_SQR_REPEAT_EN
            cnt_rem   <= sqr_count(cmd_cnt);
`endif
            case (cmd_op)
              OP_ADD: begin
                state  <= ST_ADD;
                alu_st <= 1'b1;
              end
              OP_MUL: begin
                state       <= ST_MUL_GO;
                alu_m_start <= 1'b1;
              end
              OP_SQR: begin
                state  <= ST_SQR;
                alu_ss <= 1'b1;
                alu_sy <= 1'b1;
              end
              default: begin
                state     <= ST_RESP;
                rsp_y     <= '0;
                rsp_valid <= 1'b1;
              end
            endcase
          end
        end

        ST_ADD: begin
          rsp_y     <= alu_y;
          alu_st    <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end

        ST_MUL_GO: begin
          state <= ST_MUL_WAIT;
        end

        ST_MUL_WAIT: begin
          if (alu_m_done) begin
            rsp_y     <= alu_y;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end

        // Each cycle feeds the square back into operand A for the next round.
        ST_SQR: begin
          op_a <= alu_y;
`ifdef ALU_SEQ_SQR_REPEAT_EN
          cnt_rem <= cnt_rem - CNT_W'(1);
`endif
          if (sqr_last) begin
            rsp_y     <= alu_y;
            alu_ss    <= 1'b0;
            alu_sy    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          alu_ss    <= 1'b0;
          alu_st    <= 1'b0;
          alu_sy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
